// File: rtl/rocket_motion_ctl_if.sv
// ---------------------------------------------------------------------------
// rocket_motion_ctl_if
// Purpose : bundles the pilot controls, environment flags and motion outputs
//           of rocket_motion_ctl into one interface.
// Signals : up, left, right         pilot controls
//           landed                  touchdown flag
//           coll_up/down/left/right collision flags
//           freeze                  hold all motion
//           x_pos, y_pos            sprite top-left position (POS_W bits)
//           started                 flight has begun
//           x_state, y_state        axis FSM state codes
//           step_x, step_y          one-cycle axis step strobes
// Modports: master drives the controls and observes the motion outputs,
//           slave is the motion controller itself.
// ---------------------------------------------------------------------------
interface rocket_motion_ctl_if #(
  parameter int POS_W = 12
);
  logic             up;
  logic             left;
  logic             right;
  logic             landed;
  logic             coll_up;
  logic             coll_down;
  logic             coll_left;
  logic             coll_right;
  logic             freeze;
  logic [POS_W-1:0] x_pos;
  logic [POS_W-1:0] y_pos;
  logic             started;
  logic [2:0]       x_state;
  logic [2:0]       y_state;
  logic             step_x;
  logic             step_y;

  modport master (
    output up, left, right, landed,
    output coll_up, coll_down, coll_left, coll_right, freeze,
    input  x_pos, y_pos, started, x_state, y_state, step_x, step_y
  );

  modport slave (
    input  up, left, right, landed,
    input  coll_up, coll_down, coll_left, coll_right, freeze,
    output x_pos, y_pos, started, x_state, y_state, step_x, step_y
  );
endinterface

// File: rtl/rocket_motion_ctl.sv
// ---------------------------------------------------------------------------
// rocket_motion_ctl
// Purpose : moves a rocket sprite on screen. Each axis has a tick counter and
//           a variable delay; an axis steps when its counter reaches
//           STEP_BASE + delay. Accelerating states shrink the delay (faster
//           motion), coasting states grow it until the axis gives up.
// Ports   : clk          system clock
//           rst_n        asynchronous active-low reset
//           bus (slave)  controls, collision/landing flags, freeze,
//                        positions, started, FSM states, step strobes
// Config  : define ROCKET_X_WRAP_EN to make x wrap around the screen edges
//           instead of clamping.
// ---------------------------------------------------------------------------
module rocket_motion_ctl #(
  parameter int POS_W        = 12,
  parameter int DLY_W        = 24,
  parameter int XPOS_MAX     = 799,
  parameter int YPOS_MAX     = 599,
  parameter int OBJ_W        = 48,
  parameter int OBJ_H        = 64,
  parameter int X_INIT       = 20,
  parameter int Y_INIT       = 496,
  parameter int STEP_BASE    = 100000,
  parameter int DELAY_MAX    = 1000000,
  parameter int DELAY_FACTOR = 2000
) (
  input logic              clk,
  input logic              rst_n,
  rocket_motion_ctl_if.slave bus
);

  // Counter is one bit wider than the delay so STEP_BASE + delay never wraps.
  localparam int               CNT_W  = DLY_W + 1;
  localparam logic [POS_W-1:0] X_LIM  = POS_W'(XPOS_MAX - OBJ_W);
  localparam logic [POS_W-1:0] Y_LIM  = POS_W'(YPOS_MAX - OBJ_H);
  localparam logic [DLY_W-1:0] D_MAX  = DLY_W'(DELAY_MAX);
  localparam logic [DLY_W-1:0] D_F1   = DLY_W'(DELAY_FACTOR);
  localparam logic [DLY_W-1:0] D_F2   = DLY_W'(2 * DELAY_FACTOR);
  localparam logic [DLY_W-1:0] D_F3   = DLY_W'(3 * DELAY_FACTOR);
  localparam logic [CNT_W-1:0] C_BASE = CNT_W'(STEP_BASE);

  typedef enum logic [2:0] {
    Y_IDLE     = 3'd0,
    UP_ACC     = 3'd1,
    UP_COAST   = 3'd2,
    DOWN_ACC   = 3'd3,
    DOWN_COAST = 3'd4
  } y_state_t;

  typedef enum logic [2:0] {
    X_IDLE  = 3'd0,
    L_ACC   = 3'd1,
    L_COAST = 3'd2,
    R_ACC   = 3'd3,
    R_COAST = 3'd4
  } x_state_t;

  logic [CNT_W-1:0] x_cnt, y_cnt;
  logic [DLY_W-1:0] x_dly, y_dly;
  x_state_t         x_st;
  y_state_t         y_st;
  logic [POS_W-1:0] x_q, y_q;
  logic             started_q;
  logic             x_step, y_step;
  logic [DLY_W-1:0] y_up_coast_dly, y_dn_coast_dly;
  logic [DLY_W-1:0] x_lc_dly, x_rc_dly;

  // Saturating delay arithmetic; the sum is formed one bit wider to catch
  // overflow before clamping to the ceiling.
  function automatic logic [DLY_W-1:0] dly_inc(input logic [DLY_W-1:0] d,
                                               input logic [DLY_W-1:0] amt);
    logic [DLY_W:0] sum;
    sum = {1'b0, d} + {1'b0, amt};
    return (sum >= {1'b0, D_MAX}) ? D_MAX : sum[DLY_W-1:0];
  endfunction

  function automatic logic [DLY_W-1:0] dly_dec(input logic [DLY_W-1:0] d,
                                               input logic [DLY_W-1:0] amt);
    return (d > amt) ? d - amt : '0;
  endfunction

  // One pixel left/right; edges either clamp or wrap depending on the build.
  function automatic logic [POS_W-1:0] move_left(input logic [POS_W-1:0] x);
`ifdef ROCKET_X_WRAP_EN
    return (x == '0) ? X_LIM : x - 1'b1;
`else
    return (x == '0) ? '0 : x - 1'b1;
`endif
  endfunction

  function automatic logic [POS_W-1:0] move_right(input logic [POS_W-1:0] x);
`ifdef ROCKET_X_WRAP_EN
    return (x >= X_LIM) ? '0 : x + 1'b1;
`else
    return (x >= X_LIM) ? x : x + 1'b1;
`endif
  endfunction

  // Step strobes are decoded straight from the registered counters so they
  // line up with the edge that performs the update; freeze masks them.
  assign x_step = !bus.freeze && (x_cnt == C_BASE + {1'b0, x_dly});
  assign y_step = !bus.freeze && (y_cnt == C_BASE + {1'b0, y_dly});

  // Coasting delays are needed both as the new value and for the
  // "gave up" comparison, so they are computed once here.
  assign y_up_coast_dly = dly_inc(y_dly, D_F2);
  assign y_dn_coast_dly = dly_inc(y_dly, D_F3);
  assign x_lc_dly       = dly_inc(x_dly, bus.right ? D_F2 : D_F1);
  assign x_rc_dly       = dly_inc(x_dly, bus.left  ? D_F2 : D_F1);

  // Vertical axis: tick counter, delay, position, FSM and the started flag.
  // Everything except the counter only moves on a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_cnt     <= '0;
      y_dly     <= D_MAX;
      y_st      <= Y_IDLE;
      y_q       <= POS_W'(Y_INIT);
      started_q <= 1'b0;
    end else if (!bus.freeze) begin
      if (y_step) begin
        y_cnt <= '0;
        case (y_st)
          Y_IDLE: begin
            y_dly <= D_MAX;
            if (bus.up) begin
              y_st      <= UP_ACC;
              started_q <= 1'b1;
            end else begin
              started_q <= 1'b0;
            end
          end
          UP_ACC: begin
            y_q   <= (y_q != '0) ? y_q - 1'b1 : '0;
            y_dly <= dly_dec(y_dly, D_F1);
            if (bus.coll_up)  y_st <= DOWN_ACC;
            else if (!bus.up) y_st <= UP_COAST;
          end
          UP_COAST: begin
            y_q   <= (y_q != '0) ? y_q - 1'b1 : '0;
            y_dly <= y_up_coast_dly;
            if (bus.coll_up)                y_st <= DOWN_ACC;
            else if (bus.up)                y_st <= UP_ACC;
            else if (y_up_coast_dly == D_MAX) y_st <= DOWN_ACC;
          end
          DOWN_ACC: begin
            if (y_q < Y_LIM) y_q <= y_q + 1'b1;
            y_dly <= dly_dec(y_dly, D_F1);
            if (bus.landed)         y_st <= Y_IDLE;
            else if (bus.coll_down) y_st <= UP_ACC;
            else if (bus.up)        y_st <= DOWN_COAST;
            else if (y_q >= Y_LIM)  y_st <= Y_IDLE;
          end
          DOWN_COAST: begin
            if (y_q < Y_LIM) y_q <= y_q + 1'b1;
            y_dly <= y_dn_coast_dly;
            if (bus.landed)                   y_st <= Y_IDLE;
            else if (bus.coll_down)           y_st <= UP_ACC;
            else if (!bus.up)                 y_st <= DOWN_ACC;
            else if (y_dn_coast_dly == D_MAX) y_st <= UP_ACC;
          end
          default: y_st <= Y_IDLE;
        endcase
      end else begin
        y_cnt <= y_cnt + 1'b1;
      end
    end
  end

  // Horizontal axis: same counter scheme. Pilot keys only launch sideways
  // motion once the flight has started, but a collision in idle always
  // pushes the rocket away from the obstacle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      x_dly <= D_MAX;
      x_st  <= X_IDLE;
      x_q   <= POS_W'(X_INIT);
    end else if (!bus.freeze) begin
      if (x_step) begin
        x_cnt <= '0;
        case (x_st)
          X_IDLE: begin
            x_dly <= D_MAX;
            if (bus.coll_right)                 x_st <= L_ACC;
            else if (bus.coll_left)             x_st <= R_ACC;
            else if (started_q && bus.left)     x_st <= L_ACC;
            else if (started_q && bus.right)    x_st <= R_ACC;
          end
          L_ACC: begin
            x_q   <= move_left(x_q);
            x_dly <= dly_dec(x_dly, D_F1);
            if (bus.landed)         x_st <= X_IDLE;
            else if (bus.coll_left) x_st <= R_ACC;
            else if (!bus.left)     x_st <= L_COAST;
          end
          L_COAST: begin
            x_q   <= move_left(x_q);
            x_dly <= x_lc_dly;
            if (bus.landed)             x_st <= X_IDLE;
            else if (bus.coll_left)     x_st <= R_ACC;
            else if (bus.left)          x_st <= L_ACC;
            else if (x_lc_dly == D_MAX) x_st <= X_IDLE;
          end
          R_ACC: begin
            x_q   <= move_right(x_q);
            x_dly <= dly_dec(x_dly, D_F1);
            if (bus.landed)          x_st <= X_IDLE;
            else if (bus.coll_right) x_st <= L_ACC;
            else if (!bus.right)     x_st <= R_COAST;
          end
          R_COAST: begin
            x_q   <= move_right(x_q);
            x_dly <= x_rc_dly;
            if (bus.landed)             x_st <= X_IDLE;
            else if (bus.coll_right)    x_st <= L_ACC;
            else if (bus.right)         x_st <= R_ACC;
            else if (x_rc_dly == D_MAX) x_st <= X_IDLE;
          end
          default: x_st <= X_IDLE;
        endcase
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  assign bus.x_pos   = x_q;
  assign bus.y_pos   = y_q;
  assign bus.started = started_q;
  assign bus.x_state = x_st;
  assign bus.y_state = y_st;
  assign bus.step_x  = x_step;
  assign bus.step_y  = y_step;

endmodule

// File: tb/tb_rocket_motion_ctl.sv
// ---------------------------------------------------------------------------
// tb_rocket_motion_ctl
// Purpose : self-checking bench for rocket_motion_ctl with small timing
//           parameters. A behavioural model predicts every step; predicted
//           post-step values are queued and compared when the DUT strobes.
// ---------------------------------------------------------------------------
module tb_rocket_motion_ctl;

  localparam int SB   = 2;
  localparam int DM   = 8;
  localparam int DF   = 2;
  localparam int XI   = 20;
  localparam int YI   = 100;
  localparam int XLIM = 799 - 48;
  localparam int YLIM = 599 - 64;

  typedef struct {
    int pos;
    int st;
    int started;
  } exp_t;

  logic clk;
  logic rst_n;

  rocket_motion_ctl_if #(.POS_W(12)) bus();

  rocket_motion_ctl #(
    .POS_W(12), .DLY_W(24), .XPOS_MAX(799), .YPOS_MAX(599),
    .OBJ_W(48), .OBJ_H(64), .X_INIT(XI), .Y_INIT(YI),
    .STEP_BASE(SB), .DELAY_MAX(DM), .DELAY_FACTOR(DF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int failures = 0;

  exp_t xq[$];
  exp_t yq[$];
  logic pend_x, pend_y;

  int m_x, m_y, m_xs, m_ys, m_xd, m_yd, m_xc, m_yc, m_started;
  int exp_sx, exp_sy;
  int cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic u, input logic l, input logic r,
                               input logic ld, input logic cu, input logic cd,
                               input logic cl, input logic cr, input logic fz);
    bus.up = u;         bus.left = l;       bus.right = r;
    bus.landed = ld;    bus.coll_up = cu;   bus.coll_down = cd;
    bus.coll_left = cl; bus.coll_right = cr; bus.freeze = fz;
  endtask

  task automatic modelReset();
    m_x = XI; m_y = YI; m_xs = 0; m_ys = 0;
    m_xd = DM; m_yd = DM; m_xc = 0; m_yc = 0; m_started = 0;
  endtask

  function automatic int decD(input int d);
    return (d - DF < 0) ? 0 : d - DF;
  endfunction

  function automatic int incD(input int d, input int a);
    return (d + a > DM) ? DM : d + a;
  endfunction

  function automatic int goLeft(input int x);
`ifdef ROCKET_X_WRAP_EN
    if (x == 0) return XLIM;
`else
    if (x == 0) return 0;
`endif
    return x - 1;
  endfunction

  function automatic int goRight(input int x);
`ifdef ROCKET_X_WRAP_EN
    if (x >= XLIM) return 0;
`else
    if (x >= XLIM) return x;
`endif
    return x + 1;
  endfunction

  // Horizontal model step; uses the started flag from before this edge.
  task automatic modelStepX();
    int ns;
    ns = m_xs;
    case (m_xs)
      0: begin
        m_xd = DM;
        if (bus.coll_right) ns = 1;
        else if (bus.coll_left) ns = 3;
        else if (m_started != 0 && bus.left) ns = 1;
        else if (m_started != 0 && bus.right) ns = 3;
      end
      1, 3: begin
        m_x  = (m_xs == 1) ? goLeft(m_x) : goRight(m_x);
        m_xd = decD(m_xd);
        if (bus.landed) ns = 0;
        else if (m_xs == 1 && bus.coll_left) ns = 3;
        else if (m_xs == 3 && bus.coll_right) ns = 1;
        else if (m_xs == 1 && !bus.left) ns = 2;
        else if (m_xs == 3 && !bus.right) ns = 4;
      end
      default: begin
        m_x = (m_xs == 2) ? goLeft(m_x) : goRight(m_x);
        if (m_xs == 2) m_xd = incD(m_xd, bus.right ? 2 * DF : DF);
        else           m_xd = incD(m_xd, bus.left  ? 2 * DF : DF);
        if (bus.landed) ns = 0;
        else if (m_xs == 2 && bus.coll_left) ns = 3;
        else if (m_xs == 4 && bus.coll_right) ns = 1;
        else if (m_xs == 2 && bus.left) ns = 1;
        else if (m_xs == 4 && bus.right) ns = 3;
        else if (m_xd == DM) ns = 0;
      end
    endcase
    m_xs = ns;
  endtask

  task automatic modelStepY();
    int ns;
    int oldy;
    ns = m_ys;
    oldy = m_y;
    case (m_ys)
      0: begin
        m_yd = DM;
        if (bus.up) begin ns = 1; m_started = 1; end
        else m_started = 0;
      end
      1: begin
        if (m_y > 0) m_y = m_y - 1;
        m_yd = decD(m_yd);
        if (bus.coll_up) ns = 3;
        else if (!bus.up) ns = 2;
      end
      2: begin
        if (m_y > 0) m_y = m_y - 1;
        m_yd = incD(m_yd, 2 * DF);
        if (bus.coll_up) ns = 3;
        else if (bus.up) ns = 1;
        else if (m_yd == DM) ns = 3;
      end
      3: begin
        if (m_y < YLIM) m_y = m_y + 1;
        m_yd = decD(m_yd);
        if (bus.landed) ns = 0;
        else if (bus.coll_down) ns = 1;
        else if (bus.up) ns = 4;
        else if (oldy >= YLIM) ns = 0;
      end
      default: begin
        if (m_y < YLIM) m_y = m_y + 1;
        m_yd = incD(m_yd, 3 * DF);
        if (bus.landed) ns = 0;
        else if (bus.coll_down) ns = 1;
        else if (!bus.up) ns = 3;
        else if (m_yd == DM) ns = 1;
      end
    endcase
    m_ys = ns;
  endtask

  // Scoreboard: on the falling edge compare any step the DUT announced last
  // cycle, check this cycle's strobes, then predict and queue the next step.
  always @(negedge clk) begin
    if (!rst_n) begin
      modelReset();
      xq.delete();
      yq.delete();
      pend_x = 1'b0;
      pend_y = 1'b0;
    end else begin
      if (pend_y) begin
        if (yq.size() == 0) checkOutput("y_spurious_step", 1, 0);
        else begin
          exp_t e;
          e = yq.pop_front();
          checkOutput("y_pos", int'(bus.y_pos), e.pos);
          checkOutput("y_state", int'(bus.y_state), e.st);
          checkOutput("started", int'(bus.started), e.started);
        end
      end
      if (pend_x) begin
        if (xq.size() == 0) checkOutput("x_spurious_step", 1, 0);
        else begin
          exp_t e;
          e = xq.pop_front();
          checkOutput("x_pos", int'(bus.x_pos), e.pos);
          checkOutput("x_state", int'(bus.x_state), e.st);
        end
      end
      exp_sx = (!bus.freeze && m_xc == SB + m_xd) ? 1 : 0;
      exp_sy = (!bus.freeze && m_yc == SB + m_yd) ? 1 : 0;
      checkOutput("step_x", int'(bus.step_x), exp_sx);
      checkOutput("step_y", int'(bus.step_y), exp_sy);
      if (exp_sx != 0) begin
        modelStepX();
        xq.push_back('{pos: m_x, st: m_xs, started: 0});
      end
      if (exp_sy != 0) begin
        modelStepY();
        yq.push_back('{pos: m_y, st: m_ys, started: m_started});
      end
      if (!bus.freeze) begin
        m_xc = (exp_sx != 0) ? 0 : m_xc + 1;
        m_yc = (exp_sy != 0) ? 0 : m_yc + 1;
      end
      pend_x = bus.step_x;
      pend_y = bus.step_y;
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_x"}, int'(bus.x_pos), XI);
    checkOutput({tag, "_y"}, int'(bus.y_pos), YI);
    checkOutput({tag, "_started"}, int'(bus.started), 0);
    checkOutput({tag, "_xstate"}, int'(bus.x_state), 0);
    checkOutput({tag, "_ystate"}, int'(bus.y_state), 0);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    checkOutput("reset_step_x", int'(bus.step_x), 0);
    checkOutput("reset_step_y", int'(bus.step_y), 0);
    rst_n = 1'b1;

    // Idle with no inputs: nothing moves.
    repeat (100) @(posedge clk);
    #1;
    checkResetOutputs("idle100");

    // Up held from reset release: first step after 11 cycles, then the
    // interval shrinks as the delay drops.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    doReset();
    cnt = 0;
    while (cnt < 50 && bus.y_state != 3'd1) begin @(posedge clk); #1; cnt++; end
    checkOutput("first_step_cycles", cnt, 11);
    checkOutput("first_step_started", int'(bus.started), 1);
    checkOutput("first_step_y", int'(bus.y_pos), YI);
    cnt = 0;
    while (cnt < 50 && bus.y_pos != 12'(YI - 1)) begin @(posedge clk); #1; cnt++; end
    checkOutput("second_step_cycles", cnt, 11);
    cnt = 0;
    while (cnt < 50 && bus.y_pos != 12'(YI - 2)) begin @(posedge clk); #1; cnt++; end
    checkOutput("third_step_cycles", cnt, 9);
    repeat (40) @(posedge clk);
    #1;

    // Release: coast up, then fall, then land.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cnt = 0;
    while (cnt < 300 && bus.y_state != 3'd3) begin @(posedge clk); #1; cnt++; end
    checkOutput("reach_down_acc", int'(bus.y_state), 3);
    repeat (30) @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    cnt = 0;
    while (cnt < 100 && bus.y_state != 3'd0) begin @(posedge clk); #1; cnt++; end
    checkOutput("landed_idle", int'(bus.y_state), 0);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("landed_hold_y", int'(bus.y_pos), m_y);

    // Sideways flight to the left edge, then a left collision.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    doReset();
    cnt = 0;
    while (cnt < 400 && bus.x_pos != 12'd0) begin @(posedge clk); #1; cnt++; end
    checkOutput("x_reach_0", int'(bus.x_pos), 0);
    cnt = 0;
    while (cnt < 50 && !bus.step_x) begin @(posedge clk); #1; cnt++; end
    @(posedge clk); #1;
`ifdef ROCKET_X_WRAP_EN
    checkOutput("x_edge_next", int'(bus.x_pos), XLIM);
`else
    checkOutput("x_edge_next", int'(bus.x_pos), 0);
`endif
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 0);
    cnt = 0;
    while (cnt < 50 && bus.x_state != 3'd3) begin @(posedge clk); #1; cnt++; end
    checkOutput("coll_left_r_acc", int'(bus.x_state), 3);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (20) @(posedge clk);
    #1;

    // Freeze mid-flight for 50 cycles.
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 1);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("freeze_x", int'(bus.x_pos), m_x);
    checkOutput("freeze_y", int'(bus.y_pos), m_y);
    checkOutput("freeze_xstate", int'(bus.x_state), m_xs);
    checkOutput("freeze_ystate", int'(bus.y_state), m_ys);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);

    // Random pilot behaviour, inputs held for a few cycles at a time.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 9) == 0));
      repeat (8) @(posedge clk);
      #1;
    end
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (40) @(posedge clk);

    // Reset pulsed in the middle of a cycle takes effect immediately.
    #3;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    checkOutput("midreset_step_x", int'(bus.step_x), 0);
    checkOutput("midreset_step_y", int'(bus.step_y), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkResetOutputs("postreset");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
